// File: rtl/down_sample_sched.sv
// -----------------------------------------------------------------------------
// down_sample_sched
//
// Shares one down_sample decimator between NCH ADC channels. Each input-rate
// strobe (en) snapshots every channel sample; the snapshot is then issued to
// the decimator one channel per clk in ascending channel order, tagged with
// its channel index. Decimator results come back a fixed LAT cycles later.
// They are re-tagged from a delay line of the issued channel numbers and
// queued in an output FIFO that the consumer drains with valid/ready.
//
// Parameters
//   W    sample width (signed two's complement, passed through bit-exact)
//   NCH  channel count (>= 2)
//   LAT  decimator latency ds_en -> ds_valid in clk cycles (>= 1)
//   FD   output FIFO depth (power of 2, >= 2)
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   en         input-rate strobe, one-cycle pulse
//   in_data    NCH packed samples, channel k = in_data[k*W +: W]
//   ds_en      issue strobe to the decimator (registered)
//   ds_ch      channel/context select, valid while ds_en = 1
//   ds_in      sample to the decimator, valid while ds_en = 1
//   ds_valid   decimator result strobe, LAT cycles after the matching ds_en
//   ds_out     decimator result
//   out_valid  FIFO holds at least one entry
//   out_ready  consumer accepts the head entry
//   out_ch     channel tag of the head entry
//   out_data   data of the head entry
//   miss       sticky: en arrived while a burst was still being issued
//   ovr        sticky: a result was dropped because the FIFO was full
//   clr        clears miss and ovr (a same-cycle set wins)
//   state_dbg  current issue FSM state (0 = IDLE, 1 = ISSUE)
//
// Output handshake: an entry moves from the FIFO to the consumer on every
// rising clk edge where out_valid & out_ready are both 1. While out_valid is 1
// and out_ready is 0, out_ch/out_data stay unchanged. out_valid never depends
// combinationally on out_ready.
// -----------------------------------------------------------------------------
module down_sample_sched #(
    parameter int W   = 24,
    parameter int NCH = 4,
    parameter int LAT = 3,
    parameter int FD  = 8,
    localparam int CHW = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NCH*W-1:0]   in_data,
    output logic               ds_en,
    output logic [CHW-1:0]     ds_ch,
    output logic [W-1:0]       ds_in,
    input  logic               ds_valid,
    input  logic [W-1:0]       ds_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CHW-1:0]     out_ch,
    output logic [W-1:0]       out_data,
    output logic               miss,
    output logic               ovr,
    input  logic               clr,
    output logic               state_dbg
);

    localparam int AW = $clog2(FD);
    localparam int PW = AW + 1;

    // -------------------------------------------------------------------------
    // Issue FSM
    // -------------------------------------------------------------------------
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CHW-1:0] idx;
    logic [CHW-1:0] idx_nxt;
    logic [W-1:0]   snap [NCH];
    logic           last_issue;
    logic           capture;
    logic           issue_nxt;
    logic [W-1:0]   sample_nxt;
    logic           miss_set;

    // idx always names the channel currently presented on ds_ch while in ISSUE.
    assign last_issue = (idx == CHW'(NCH - 1));
    assign state_dbg  = state;

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        capture    = 1'b0;
        issue_nxt  = 1'b0;
        sample_nxt = '0;
        miss_set   = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    // Channel 0 goes out straight from in_data so it appears
                    // on the cycle right after the capture edge.
                    capture    = 1'b1;
                    state_nxt  = ISSUE;
                    idx_nxt    = '0;
                    issue_nxt  = 1'b1;
                    sample_nxt = in_data[W-1:0];
                end
            end
            ISSUE: begin
                // A strobe that lands on any issue cycle, including the last,
                // is not captured and does not restart the burst.
                if (en) begin
                    miss_set = 1'b1;
                end
                if (last_issue) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt    = idx + 1'b1;
                    issue_nxt  = 1'b1;
                    sample_nxt = snap[idx_nxt];
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            ds_en <= 1'b0;
            ds_ch <= '0;
            ds_in <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            ds_en <= issue_nxt;
            ds_ch <= issue_nxt ? idx_nxt : '0;
            ds_in <= sample_nxt;
        end
    end

    // Snapshot holds the samples for the whole burst so in_data may change
    // freely after the capture edge.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < NCH; k++) begin
                snap[k] <= in_data[k*W +: W];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Tag pipe: delays {ds_en, ds_ch} by LAT cycles so the last stage lines up
    // with the decimator result that belongs to it.
    // -------------------------------------------------------------------------
    logic           tag_v  [LAT];
    logic [CHW-1:0] tag_ch [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_v[i]  <= 1'b0;
                tag_ch[i] <= '0;
            end
        end else begin
            tag_v[0]  <= ds_en;
            tag_ch[0] <= ds_ch;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_ch[i] <= tag_ch[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output FIFO. Pointers carry one extra wrap bit: equal pointers mean
    // empty, equal low bits with differing wrap bits mean full.
    // -------------------------------------------------------------------------
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CHW+W-1:0]   mem [FD];
    logic [CHW+W-1:0]   head;
    logic               empty;
    logic               full;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A result without a matching issue LAT cycles earlier is ignored.
    assign push_req = ds_valid & tag_v[LAT-1];
    assign pop      = ~empty & out_ready;
    // When full, a same-cycle pop frees the head slot, which is exactly the
    // slot the write lands in, so the write can still be accepted.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr[AW-1:0]] <= {tag_ch[LAT-1], ds_out};
        end
    end

    // Head is read from storage, so a write shows up one cycle later and the
    // head cannot change while it is not being popped. Outputs read as zero
    // when empty so nothing undefined leaves the block.
    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_valid = ~empty;
    assign out_ch    = empty ? '0 : head[CHW+W-1:W];
    assign out_data  = empty ? '0 : head[W-1:0];

    // -------------------------------------------------------------------------
    // Sticky status flags: a set in the same cycle as clr takes priority.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            miss <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            if (miss_set) begin
                miss <= 1'b1;
            end else if (clr) begin
                miss <= 1'b0;
            end
            if (drop) begin
                ovr <= 1'b1;
            end else if (clr) begin
                ovr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_down_sample_sched.sv
// -----------------------------------------------------------------------------
// tb_down_sample_sched
//
// Directed bench for down_sample_sched with NCH=4, LAT=3, FD=8. A stub
// decimator echoes ds_in back as ds_out exactly LAT cycles after ds_en.
// Inputs are driven and outputs sampled 1 ns after the rising clk edge.
// -----------------------------------------------------------------------------
module tb_down_sample_sched;

    localparam int W   = 24;
    localparam int NCH = 4;
    localparam int LAT = 3;
    localparam int FD  = 8;
    localparam int CHW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic [NCH*W-1:0]   in_data = '0;
    logic               ds_en;
    logic [CHW-1:0]     ds_ch;
    logic [W-1:0]       ds_in;
    logic               ds_valid;
    logic [W-1:0]       ds_out;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [CHW-1:0]     out_ch;
    logic [W-1:0]       out_data;
    logic               miss;
    logic               ovr;
    logic               clr = 1'b0;
    logic               state_dbg;

    down_sample_sched #(
        .W   (W),
        .NCH (NCH),
        .LAT (LAT),
        .FD  (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_data   (in_data),
        .ds_en     (ds_en),
        .ds_ch     (ds_ch),
        .ds_in     (ds_in),
        .ds_valid  (ds_valid),
        .ds_out    (ds_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .miss      (miss),
        .ovr       (ovr),
        .clr       (clr),
        .state_dbg (state_dbg)
    );

    // ---------------- stub decimator: echo with fixed latency ----------------
    logic [LAT-1:0] stub_v = '0;
    logic [W-1:0]   stub_d [LAT];

    always @(posedge clk) begin
        stub_v    <= {stub_v[LAT-2:0], ds_en};
        stub_d[0] <= ds_in;
        for (int i = 1; i < LAT; i++) begin
            stub_d[i] <= stub_d[i-1];
        end
    end

    assign ds_valid = stub_v[LAT-1];
    assign ds_out   = stub_d[LAT-1];

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [CHW+W-1:0] exp_q [$];
    logic [CHW+W-1:0] got_q [$];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pat(input int b, input int c);
        return 24'h800000 | 24'(b * 256 + c);
    endfunction

    task automatic load_pattern(input int b);
        for (int c = 0; c < NCH; c++) begin
            in_data[c*W +: W] = pat(b, c);
        end
    endtask

    // One en pulse, then enough cycles for all NCH results to reach the FIFO.
    task automatic send_burst();
        en = 1'b1;
        tick();
        en = 1'b0;
        repeat (8) tick();
    endtask

    // Pops up to n_want entries into got_q within max_cycles.
    task automatic collect(input int max_cycles, input int n_want);
        out_ready = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            if (got_q.size() >= n_want) break;
            if (out_valid) got_q.push_back({out_ch, out_data});
            tick();
        end
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (5) tick();
        n_checks++; if (ds_en !== 1'b0) begin n_fail++; $display("FAIL reset_ds_en: got %0h expected 0", ds_en); end
        n_checks++; if (ds_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ds_ch: got %0h expected 0", ds_ch); end
        n_checks++; if (ds_in !== 24'd0) begin n_fail++; $display("FAIL reset_ds_in: got %0h expected 0", ds_in); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0h expected 0", out_valid); end
        n_checks++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_out_ch: got %0h expected 0", out_ch); end
        n_checks++; if (out_data !== 24'd0) begin n_fail++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
        n_checks++; if (miss !== 1'b0) begin n_fail++; $display("FAIL reset_miss: got %0h expected 0", miss); end
        n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %0h expected 0", ovr); end
        n_checks++; if (state_dbg !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %0h expected 0", state_dbg); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_issue();
        out_ready = 1'b0;
        in_data = {24'd4, 24'd3, 24'd2, 24'd1};
        en = 1'b1;
        tick();
        en = 1'b0;
        // The burst must come from the snapshot, not the live input.
        in_data = '1;
        for (int k = 0; k < NCH; k++) begin
            n_checks++; if (ds_en !== 1'b1) begin n_fail++; $display("FAIL issue_ds_en[%0d]: got %0h expected 1", k, ds_en); end
            n_checks++; if (ds_ch !== 2'(k)) begin n_fail++; $display("FAIL issue_ds_ch[%0d]: got %0h expected %0h", k, ds_ch, k); end
            n_checks++; if (ds_in !== 24'(k + 1)) begin n_fail++; $display("FAIL issue_ds_in[%0d]: got %0h expected %0h", k, ds_in, k + 1); end
            n_checks++; if (state_dbg !== 1'b1) begin n_fail++; $display("FAIL issue_state[%0d]: got %0h expected 1", k, state_dbg); end
            tick();
        end
        n_checks++; if (ds_en !== 1'b0) begin n_fail++; $display("FAIL issue_end_ds_en: got %0h expected 0", ds_en); end
        n_checks++; if (state_dbg !== 1'b0) begin n_fail++; $display("FAIL issue_end_state: got %0h expected 0", state_dbg); end
    endtask

    task automatic test_stream();
        logic [CHW+W-1:0] got;
        got_q.delete();
        collect(30, 4);
        n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL stream_count: got %0d expected 4", got_q.size()); end
        for (int k = 0; k < 4; k++) begin
            got = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_checks++; if (got !== {2'(k), 24'(k + 1)}) begin n_fail++; $display("FAIL stream_entry[%0d]: got %0h expected %0h", k, got, {2'(k), 24'(k + 1)}); end
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got %0h expected 0", out_valid); end
    endtask

    task automatic test_miss();
        int issues;
        issues = 0;
        out_ready = 1'b1;
        load_pattern(9);
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (ds_en) issues++;
            en = (i == 1);
            tick();
        end
        en = 1'b0;
        n_checks++; if (issues != 4) begin n_fail++; $display("FAIL miss_issue_count: got %0d expected 4", issues); end
        n_checks++; if (miss !== 1'b1) begin n_fail++; $display("FAIL miss_set: got %0h expected 1", miss); end
        n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL miss_ovr: got %0h expected 0", ovr); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++; if (miss !== 1'b0) begin n_fail++; $display("FAIL miss_clr: got %0h expected 0", miss); end
        out_ready = 1'b0;
    endtask

    task automatic test_miss_last();
        int issues;
        issues = 0;
        out_ready = 1'b1;
        load_pattern(10);
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (ds_en) issues++;
            if (i == 3) begin
                n_checks++; if (ds_ch !== 2'd3) begin n_fail++; $display("FAIL last_ds_ch: got %0h expected 3", ds_ch); end
            end
            // en on the last issue cycle together with clr: the set must win.
            en  = (i == 3);
            clr = (i == 3);
            tick();
        end
        en  = 1'b0;
        clr = 1'b0;
        n_checks++; if (issues != 4) begin n_fail++; $display("FAIL last_issue_count: got %0d expected 4", issues); end
        n_checks++; if (miss !== 1'b1) begin n_fail++; $display("FAIL last_miss_set_wins: got %0h expected 1", miss); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++; if (miss !== 1'b0) begin n_fail++; $display("FAIL last_miss_clr: got %0h expected 0", miss); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_start_empty: got %0h expected 0", out_valid); end
        for (int b = 0; b < 3; b++) begin
            load_pattern(b);
            send_burst();
            if (b == 1) begin
                n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovf_exact_full_ovr: got %0h expected 0", ovr); end
            end
        end
        n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovf_ovr: got %0h expected 1", ovr); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_hold_valid[%0d]: got %0h expected 1", i, out_valid); end
            n_checks++; if ({out_ch, out_data} !== {2'd0, pat(0, 0)}) begin n_fail++; $display("FAIL ovf_hold_head[%0d]: got %0h expected %0h", i, {out_ch, out_data}, {2'd0, pat(0, 0)}); end
            tick();
        end
    endtask

    task automatic test_full_pop();
        logic any_empty;
        logic [CHW+W-1:0] got;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL fp_ovr_clr: got %0h expected 0", ovr); end
        any_empty = 1'b0;
        load_pattern(3);
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            // Pop exactly on the cycles a result arrives at a full FIFO.
            out_ready = ds_valid;
            if (!out_valid) any_empty = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL fp_no_ovr: got %0h expected 0", ovr); end
        n_checks++; if (any_empty !== 1'b0) begin n_fail++; $display("FAIL fp_never_empty: got %0h expected 0", any_empty); end
        exp_q.delete();
        for (int c = 0; c < NCH; c++) exp_q.push_back({2'(c), pat(1, c)});
        for (int c = 0; c < NCH; c++) exp_q.push_back({2'(c), pat(3, c)});
        got_q.delete();
        collect(40, 8);
        n_checks++; if (got_q.size() != 8) begin n_fail++; $display("FAIL fp_count: got %0d expected 8", got_q.size()); end
        for (int k = 0; k < 8; k++) begin
            got = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_checks++; if (got !== exp_q[k]) begin n_fail++; $display("FAIL fp_entry[%0d]: got %0h expected %0h", k, got, exp_q[k]); end
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fp_drained: got %0h expected 0", out_valid); end
    endtask

    task automatic test_rst_mid();
        int writes;
        int issues;
        out_ready = 1'b0;
        load_pattern(4);
        send_burst();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %0h expected 1", out_valid); end
        load_pattern(5);
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        n_checks++; if ({ds_en, ds_ch} !== 3'b101) begin n_fail++; $display("FAIL rst_second_issue: got %0h expected 5", {ds_en, ds_ch}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (ds_en !== 1'b0) begin n_fail++; $display("FAIL rst_ds_en: got %0h expected 0", ds_en); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0h expected 0", out_valid); end
        n_checks++; if (state_dbg !== 1'b0) begin n_fail++; $display("FAIL rst_state: got %0h expected 0", state_dbg); end
        writes = 0;
        issues = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) writes++;
            if (ds_en) issues++;
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (writes != 0) begin n_fail++; $display("FAIL rst_late_writes: got %0d expected 0", writes); end
        n_checks++; if (issues != 0) begin n_fail++; $display("FAIL rst_late_issues: got %0d expected 0", issues); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_issue();
        test_stream();
        test_miss();
        test_miss_last();
        test_overflow();
        test_full_pop();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
